// File: rtl/pwm_reg_pkg.sv
// pwm_reg_pkg
// Shared definitions for the PWM register-bus master: register address map,
// the table of legal addresses, per-register read masks and the FSM state type.
// No ports (package).
package pwm_reg_pkg;

    localparam int unsigned ADDR_CTRL   = 32'h00;
    localparam int unsigned ADDR_PERIOD = 32'h04;
    localparam int unsigned ADDR_DUTY   = 32'h08;
    localparam int unsigned ADDR_CH0    = 32'h0C;
    localparam int unsigned ADDR_CH1    = 32'h0D;
    localparam int unsigned ADDR_CH2    = 32'h0E;
    localparam int unsigned ADDR_POL    = 32'h0F;
    localparam int unsigned ADDR_DEAD   = 32'h10;
    localparam int unsigned ADDR_STATUS = 32'h14;

    localparam int N_LEGAL = 9;
    localparam int unsigned LEGAL_ADDRS [N_LEGAL] = '{
        ADDR_CTRL, ADDR_PERIOD, ADDR_DUTY, ADDR_CH0, ADDR_CH1,
        ADDR_CH2, ADDR_POL, ADDR_DEAD, ADDR_STATUS
    };

    // Bits that actually read back; unlisted registers read back all bits.
    localparam logic [15:0] MASK_CTRL = 16'h0003;
    localparam logic [15:0] MASK_POL  = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_reg_addr_dec.sv
// pwm_reg_addr_dec
// Combinational address decoder for the PWM register map.
// Ports:
//   addr  - register address to classify
//   legal - 1 when addr is one of the implemented registers
//   mask  - read-back mask for addr (all-ones for full-width registers)
module pwm_reg_addr_dec
    import pwm_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              legal,
    output logic [WIDTH-1:0]  mask
);

    always_comb begin
        legal = 1'b0;
        for (int i = 0; i < N_LEGAL; i++) begin
            if (32'(addr) == LEGAL_ADDRS[i]) begin
                legal = 1'b1;
            end
        end

        mask = '1;
        if (32'(addr) == ADDR_CTRL) begin
            mask = WIDTH'(MASK_CTRL);
        end else if (32'(addr) == ADDR_POL) begin
            mask = WIDTH'(MASK_POL);
        end
    end

endmodule

// File: rtl/pwm_reg_master.sv
// pwm_reg_master
// Turns single read/write commands into one-cycle strobes on the PWM
// register bus and returns a response with error reporting.
// Build option: define PWM_REG_MASTER_VERIFY_EN to read back every write
// and flag a masked mismatch as an error.
// Ports:
//   clk, rst                              - clock, async active-high reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_data                    - command channel
//   wr_en, rd_en, addr, wr_data, rd_data  - register-bus initiator
//   rsp_valid/rsp_ready, rsp_data, rsp_err- response channel
//   err_cnt                               - saturating error-response count
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | ready for a command
// ST_ISSUE  | one-cycle wr_en or rd_en strobe on the bus
// ST_VERIFY | read-back strobe after a write (VERIFY_EN builds only)
// ST_RESP   | response held until rsp_ready
module pwm_reg_master
    import pwm_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [7:0]        err_cnt
);

    state_t              state;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    data_q;
    logic [ADDR_W-1:0]   dec_addr;
    logic                dec_legal;
    logic [WIDTH-1:0]    dec_mask;

    // One decoder serves both the incoming command and the latched one.
    assign dec_addr  = (state == ST_IDLE) ? cmd_addr : addr_q;
    // Combinational so it is low throughout reset and high right after.
    assign cmd_ready = (state == ST_IDLE) && !rst;

    pwm_reg_addr_dec #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr_dec (
        .addr  (dec_addr),
        .legal (dec_legal),
        .mask  (dec_mask)
    );

`ifndef PWM_REG_MASTER_VERIFY_EN
    logic unused_mask;
    assign unused_mask = ^dec_mask;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            // Strobes and bus fields default low so they last one cycle.
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        write_q <= cmd_write;
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        if (dec_legal) begin
                            state   <= ST_ISSUE;
                            wr_en   <= cmd_write;
                            rd_en   <= !cmd_write;
                            addr    <= cmd_addr;
                            wr_data <= cmd_write ? cmd_data : '0;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (write_q) begin
`ifdef PWM_REG_MASTER_VERIFY_EN
                        state <= ST_VERIFY;
                        rd_en <= 1'b1;
                        addr  <= addr_q;
`else
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= data_q;
`endif
                    end else begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= rd_data;
                    end
                end

                ST_VERIFY: begin
`ifdef PWM_REG_MASTER_VERIFY_EN
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    if ((rd_data & dec_mask) != (data_q & dec_mask)) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= rd_data;
                    end else begin
                        rsp_err  <= 1'b0;
                        rsp_data <= data_q;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        if (rsp_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_reg_master.sv
// tb_pwm_reg_master
// Directed and randomized commands against pwm_reg_master with a simple
// PWM register-file device and a transaction-level expectation model.
module tb_pwm_reg_master;

`ifdef PWM_REG_MASTER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        wr_en, rd_en;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] dev_mem   [32];
    logic [15:0] model_mem [32];
    int          model_err = 0;
    logic [4:0]  legal_list [9] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h0D,
                                    5'h0E, 5'h0F, 5'h10, 5'h14};

    always #5 clk = ~clk;

    pwm_reg_master #(.WIDTH(16), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
    );

    function automatic logic [15:0] mask_of(input logic [4:0] a);
        case (a)
            5'h00:   return 16'h0003;
            5'h0F:   return 16'h0001;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] a);
        return a inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h14};
    endfunction

    // Register-file device: stores only implemented bits, reads combinationally.
    assign rd_data = rd_en ? dev_mem[addr] : 16'h0000;
    always @(posedge clk) begin
        if (wr_en) dev_mem[addr] <= wr_data & mask_of(addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus rules that hold on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_exclusive", {31'b0, wr_en && rd_en}, 32'd0);
            if (!wr_en && !rd_en) begin
                chk("idle_addr", {27'b0, addr}, 32'd0);
                chk("idle_wdata", {16'b0, wr_data}, 32'd0);
            end
        end
    end

    task automatic run_cmd(input bit w, input logic [4:0] a, input logic [15:0] d,
                           input int stall, input bit hold);
        bit          legal;
        bit          exp_err;
        logic [15:0] exp_data;
        int          exp_wr_off, exp_rd_off, exp_wr_cnt, exp_rd_cnt, exp_rsp_off;
        int          wr_off, rd_off, wr_cnt, rd_cnt, rsp_off;
        logic [15:0] held;
        bit          done;

        legal = is_legal(a);
        wr_off = -1; rd_off = -1; wr_cnt = 0; rd_cnt = 0; rsp_off = -1;
        held = '0; done = 1'b0;
        if (!legal) begin
            exp_err = 1'b1; exp_data = 16'h0000;
            exp_wr_off = -1; exp_rd_off = -1; exp_wr_cnt = 0; exp_rd_cnt = 0;
            exp_rsp_off = 1;
        end else if (w) begin
            exp_err = 1'b0; exp_data = d;
            exp_wr_off = 1; exp_wr_cnt = 1;
            exp_rd_off = VERIFY ? 2 : -1;
            exp_rd_cnt = VERIFY ? 1 : 0;
            exp_rsp_off = VERIFY ? 3 : 2;
        end else begin
            exp_err = 1'b0; exp_data = model_mem[a];
            exp_wr_off = -1; exp_wr_cnt = 0; exp_rd_off = 1; exp_rd_cnt = 1;
            exp_rsp_off = 2;
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d; rsp_ready = 1'b0;
        #1 chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            chk("busy_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            if (wr_en) begin
                wr_cnt++;
                if (wr_off < 0) wr_off = k;
                chk("wr_addr", {27'b0, addr}, {27'b0, a});
                chk("wr_data", {16'b0, wr_data}, {16'b0, d});
            end
            if (rd_en) begin
                rd_cnt++;
                if (rd_off < 0) rd_off = k;
                chk("rd_addr", {27'b0, addr}, {27'b0, a});
            end
            if (rsp_valid) begin
                if (rsp_off < 0) begin
                    rsp_off = k;
                    held = rsp_data;
                    chk("rsp_latency", k, exp_rsp_off);
                    chk("rsp_data", {16'b0, rsp_data}, {16'b0, exp_data});
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
                end else begin
                    chk("rsp_stable", {16'b0, rsp_data}, {16'b0, held});
                end
                if (k - rsp_off >= stall) begin
                    cmd_valid = 1'b0;
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
        chk("wr_count", wr_cnt, exp_wr_cnt);
        chk("rd_count", rd_cnt, exp_rd_cnt);
        chk("wr_latency", wr_off, exp_wr_off);
        chk("rd_latency", rd_off, exp_rd_off);

        if (legal && w) model_mem[a] = d & mask_of(a);
        if (exp_err && model_err < 255) model_err++;

        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_released", {31'b0, rsp_valid}, 32'd0);
        chk("err_cnt", {24'b0, err_cnt}, model_err);
    endtask

    initial begin
        bit          w;
        logic [4:0]  a;
        logic [15:0] d;

        for (int i = 0; i < 32; i++) begin
            dev_mem[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1 chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Directed: period write/read, masked ctrl write, illegal address, stall.
        run_cmd(1'b1, 5'h04, 16'h03E8, 0, 1'b0);
        run_cmd(1'b0, 5'h04, 16'h0000, 0, 1'b0);
        run_cmd(1'b1, 5'h00, 16'hFFFF, 0, 1'b0);
        run_cmd(1'b0, 5'h00, 16'h0000, 0, 1'b0);
        run_cmd(1'b1, 5'h0F, 16'h1236, 1, 1'b0);
        run_cmd(1'b0, 5'h0F, 16'h0000, 0, 1'b0);
        run_cmd(1'b0, 5'h05, 16'h0000, 0, 1'b0);
        run_cmd(1'b1, 5'h10, 16'hBEEF, 10, 1'b1);
        run_cmd(1'b1, 5'h1F, 16'h5555, 10, 1'b1);

        // Randomized mix of legal and arbitrary addresses.
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) a = legal_list[$urandom_range(0, 8)];
            else a = 5'($urandom_range(0, 31));
            d = 16'($urandom);
            run_cmd(w, a, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset while a write to 0x10 is on the bus.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h10; cmd_data = 16'hABCD;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("mid_rst_addr", {27'b0, addr}, 32'd0);
        chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        model_err = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {30'b0, rsp_valid, wr_en}, 32'd0);
        end
        run_cmd(1'b0, 5'h10, 16'h0000, 0, 1'b0);

        // Error counter saturation.
        for (int n = 0; n < 256; n++) begin
            run_cmd(1'($urandom_range(0, 1)), 5'h05, 16'($urandom), 0, 1'b0);
        end
        chk("err_cnt_saturated", {24'b0, err_cnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_reg_master.md
PWM_REG_MASTER -- requirements
Module: pwm_reg_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of the register bus.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (covers 0x00..0x14).
REQ-003 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1, cmd_ready  output  1  command handshake.
REQ-006 SHALL have cmd_write  input  1 (1=write, 0=read); cmd_addr  input  ADDR_W; cmd_data  input  WIDTH.
REQ-007 SHALL have wr_en  output  1, rd_en  output  1, addr  output  ADDR_W, wr_data  output  WIDTH  register-bus initiator side.
REQ-008 SHALL have rd_data  input  WIDTH  combinational read data returned by the PWM register file while rd_en is high.
REQ-009 SHALL have rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  WIDTH, rsp_err  output  1  response handshake.
REQ-010 SHALL have err_cnt  output  8  saturating count of responses with rsp_err=1.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, VERIFY, RESP.
REQ-012 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch write/addr/data; go to ISSUE if addr legal, else RESP with rsp_err=1, rsp_data=0, no bus strobe.
REQ-013 Legal addresses: 0x00,0x04,0x08,0x0C,0x0D,0x0E,0x0F,0x10,0x14; all others illegal.
REQ-014 ISSUE: assert exactly one of wr_en/rd_en for exactly one cycle, addr/wr_data driven from latched command; wr_data=0 on reads.
REQ-015 ISSUE read: capture rd_data at end of the ISSUE cycle into rsp_data, rsp_err=0, go to RESP.
REQ-016 ISSUE write: rsp_data=latched write data, rsp_err=0, go to RESP (or VERIFY, see REQ-025).
REQ-017 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&&rsp_ready; then IDLE; cmd_ready=0 in all states except IDLE.
REQ-018 Latency: accept at cycle N, strobe at N+1, rsp_valid at N+2; illegal address rsp_valid at N+1.
REQ-019 wr_en and rd_en SHALL never be high together; addr and wr_data SHALL be 0 whenever both strobes are low.
REQ-020 err_cnt SHALL increment on each rsp handshake with rsp_err=1 and saturate at 255.
REQ-021 rsp_ready held low SHALL stall indefinitely with no further bus activity and no command acceptance.

Reset
REQ-022 rst SHALL asynchronously force state IDLE, cmd_ready=0 while rst high, wr_en=0, rd_en=0, addr=0, wr_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_cnt=0.
REQ-023 Reset during ISSUE/VERIFY/RESP SHALL drop strobes and discard the command without response; first cycle after release cmd_ready=1.

Configuration
REQ-024 Macro PWM_REG_MASTER_VERIFY_EN SHALL control write read-back verification.
REQ-025 With macro: after a write ISSUE go to VERIFY, assert rd_en one cycle at same addr, compare (rd_data & mask[addr]) with (written data & mask[addr]); mismatch sets rsp_err=1, rsp_data=rd_data; write rsp_valid at N+3.
REQ-026 Without macro: no VERIFY state logic; writes respond at N+2 with rsp_err=0.

Structure
REQ-027 Shared package pwm_reg_pkg SHALL hold register address constants, the legal-address list, and per-address read masks (0x00->0x0003, 0x0F->0x0001, others all-ones).
REQ-028 Sub-module pwm_reg_addr_dec SHALL be combinational: addr -> legal flag and mask; no other sub-modules.

Verification
REQ-029 Write 0x04<=0x03E8 then read 0x04 -> wr_en one cycle at N+1, read rsp_data=0x03E8, rsp_err=0.
REQ-030 Write 0x00<=0xFFFF with VERIFY_EN -> rd_en at N+2, rsp_valid at N+3, rsp_err=0 (masked compare 0x0003).
REQ-031 Command addr 0x05 -> no strobes, rsp_valid at N+1, rsp_err=1, err_cnt 0->1.
REQ-032 rsp_ready low 10 cycles with cmd_valid high -> cmd_ready=0, single strobe only, response held stable.
REQ-033 Assert rst during ISSUE of write 0x10 -> wr_en falls immediately, no response, cmd_ready=1 first cycle after release.
REQ-034 256 illegal commands -> err_cnt saturates at 255.
